// File: rtl/exposure_timer.sv
// Exposure interval timer: button-adjustable exposure time in ms, a prescaled
// ms countdown while Start is held, and a one-cycle Ovf5 pulse at the end.
module exposure_timer #(
  parameter int TICKS_PER_MS = 1000,
  parameter int T_MIN        = 2,
  parameter int T_MAX        = 30,
  parameter int T_RESET      = 10
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Exp_increase,
  input  logic       Exp_decrease,
  input  logic       Start,
  output logic       Ovf5,
  output logic [4:0] Exp_time,
  output logic       Busy,
  output logic [1:0] dbg_state
);

  localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_MS - 1);
  localparam logic [4:0] TMAX5 = 5'(T_MAX);
  localparam logic [4:0] TMIN5 = 5'(T_MIN);
  localparam logic [4:0] TRST5 = 5'(T_RESET);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [4:0]    ms_q, ms_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [4:0]    exp_d;
  logic          ovf_d, busy_d;
  logic          inc_q, dec_q, start_q;
  logic          inc_rise, dec_rise, start_rise;

  assign inc_rise   = Exp_increase & ~inc_q;
  assign dec_rise   = Exp_decrease & ~dec_q;
  assign start_rise = Start & ~start_q;
  assign dbg_state  = state_q;

  always_comb begin
    state_d = state_q;
    ms_d    = ms_q;
    pre_d   = pre_q;
    exp_d   = Exp_time;
    ovf_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // A Start edge wins over coincident button edges.
        if (start_rise) begin
          state_d = RUN;
          ms_d    = Exp_time;
          pre_d   = '0;
        end else if (inc_rise && !dec_rise) begin
          if (Exp_time < TMAX5) exp_d = Exp_time + 5'd1;
        end else if (dec_rise && !inc_rise) begin
          if (Exp_time > TMIN5) exp_d = Exp_time - 5'd1;
        end
      end
      RUN: begin
        if (!Start) begin
          state_d = IDLE;
          ms_d    = '0;
          pre_d   = '0;
        end else if (pre_q == PRE_LAST) begin
          pre_d = '0;
          if (ms_q <= 5'd1) begin
            state_d = DONE;
            ovf_d   = 1'b1;
            ms_d    = '0;
          end else begin
            ms_d = ms_q - 5'd1;
          end
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
      DONE: begin
        if (!Start) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        ms_d    = '0;
        pre_d   = '0;
      end
    endcase
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      ms_q     <= '0;
      pre_q    <= '0;
      Exp_time <= TRST5;
      Ovf5     <= 1'b0;
      Busy     <= 1'b0;
      // Inputs held high through reset release must not look like edges.
      inc_q    <= 1'b1;
      dec_q    <= 1'b1;
      start_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      ms_q     <= ms_d;
      pre_q    <= pre_d;
      Exp_time <= exp_d;
      Ovf5     <= ovf_d;
      Busy     <= busy_d;
      inc_q    <= Exp_increase;
      dec_q    <= Exp_decrease;
      start_q  <= Start;
    end
  end

endmodule

// File: tb/tb_exposure_timer.sv
// Bench for exposure_timer: directed scenarios plus random traffic, checked
// per cycle against an end-cycle based reference model through a queue.
module tb_exposure_timer;

  localparam int TICKS   = 4;
  localparam int T_MIN   = 2;
  localparam int T_MAX   = 30;
  localparam int T_RESET = 10;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Exp_increase = 1'b0;
  logic       Exp_decrease = 1'b0;
  logic       Start = 1'b0;
  logic       Ovf5;
  logic [4:0] Exp_time;
  logic       Busy;
  logic [1:0] dbg_state;

  exposure_timer #(
    .TICKS_PER_MS(TICKS),
    .T_MIN(T_MIN),
    .T_MAX(T_MAX),
    .T_RESET(T_RESET)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Exp_increase(Exp_increase),
    .Exp_decrease(Exp_decrease),
    .Start(Start),
    .Ovf5(Ovf5),
    .Exp_time(Exp_time),
    .Busy(Busy),
    .dbg_state(dbg_state)
  );

  always #5 Clk = ~Clk;

  // Scoreboard: {ovf, busy, exp_time} expected after each rising edge.
  logic [6:0] exp_q[$];
  int         cyc_q[$];
  int         errors = 0;
  int         checks = 0;

  // Reference model state: mode 0 idle, 1 timing, 2 finished.
  int m_mode = 0;
  int m_exp  = T_RESET;
  int m_end  = 0;
  int cyc    = 0;
  bit p_inc = 1'b1, p_dec = 1'b1, p_start = 1'b1;
  int n_ovf_expected = 0;

  task automatic model_step(input bit rst, input bit inc, input bit dec, input bit st);
    bit ovf;
    bit ri, rd, rs;
    ovf = 1'b0;
    if (rst) begin
      m_mode = 0;
      m_exp  = T_RESET;
      p_inc = 1'b1; p_dec = 1'b1; p_start = 1'b1;
    end else begin
      ri = inc & ~p_inc;
      rd = dec & ~p_dec;
      rs = st & ~p_start;
      case (m_mode)
        0: begin
          if (rs) begin
            m_mode = 1;
            m_end  = cyc + m_exp * TICKS;
          end else if (ri && !rd) begin
            m_exp = (m_exp + 1 > T_MAX) ? T_MAX : m_exp + 1;
          end else if (rd && !ri) begin
            m_exp = (m_exp - 1 < T_MIN) ? T_MIN : m_exp - 1;
          end
        end
        1: begin
          if (!st) m_mode = 0;
          else if (cyc == m_end) begin
            m_mode = 2;
            ovf = 1'b1;
            n_ovf_expected++;
          end
        end
        default: if (!st) m_mode = 0;
      endcase
      p_inc = inc; p_dec = dec; p_start = st;
    end
    exp_q.push_back({ovf, (m_mode == 1), 5'(m_exp)});
    cyc_q.push_back(cyc);
    cyc++;
  endtask

  task automatic drive(input bit rst, input bit inc, input bit dec, input bit st);
    @(negedge Clk);
    Reset = rst;
    Exp_increase = inc;
    Exp_decrease = dec;
    Start = st;
    model_step(rst, inc, dec, st);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, Start);
  endtask

  // Monitor: compares DUT outputs after each edge with the queued expectation.
  initial begin
    logic [6:0] e;
    int c;
    forever begin
      @(posedge Clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        checks++;
        if ({Ovf5, Busy, Exp_time} !== e) begin
          errors++;
          $display("FAIL outputs cyc=%0d got ovf=%b busy=%b exp=%0d want ovf=%b busy=%b exp=%0d",
                   c, Ovf5, Busy, Exp_time, e[6], e[5], e[4:0]);
        end
      end
    end
  end

  int seen_ovf = 0;
  always @(negedge Clk) if (Ovf5 === 1'b1) seen_ovf++;

  initial begin
    // Reset, then idle.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    // Saturation at both ends.
    for (int i = 0; i < 25; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
    end
    // Shortest exposure, Start held well past the end.
    for (int i = 0; i < 16; i++) drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    // Button during RUN, then abort.
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    // Button edge coinciding with the Start edge.
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    // Simultaneous button edges.
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    // Inputs held high across reset release.
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    // Reset mid-RUN at cycle 20 of a 40-cycle exposure.
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      if (i == 0) break;
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 30; i++) drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      bit st;
      st = Start;
      if ($urandom_range(0, 47) == 0) st = ~st;
      drive(($urandom_range(0, 799) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0), st);
    end
    idle(3);
    @(posedge Clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    checks++;
    if (seen_ovf != n_ovf_expected) begin
      errors++;
      $display("FAIL ovf_count got %0d want %0d", seen_ovf, n_ovf_expected);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exposure_timer.md
EXPOSURE_TIMER -- requirements
Module: exposure_timer

Interface
REQ-001 The block SHALL have parameter TICKS_PER_MS, default 1000, giving the number of Clk cycles per millisecond of exposure.
REQ-002 The block SHALL have parameter T_MIN, default 2, giving the minimum exposure time in ms.
REQ-003 The block SHALL have parameter T_MAX, default 30, giving the maximum exposure time in ms.
REQ-004 The block SHALL have parameter T_RESET, default 10, giving the exposure time in ms loaded at reset; it SHALL satisfy T_MIN <= T_RESET <= T_MAX.
REQ-005 Clk  input  1  clock; all state updates on the rising edge.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 Exp_increase  input  1  increase button, level, synchronous to Clk.
REQ-008 Exp_decrease  input  1  decrease button, level, synchronous to Clk.
REQ-009 Start  input  1  exposure request from the exposure-control FSM; held high for the whole exposure.
REQ-010 Ovf5  output  1  one-cycle pulse marking the end of the exposure interval.
REQ-011 Exp_time  output  5  current exposure setting in ms, unsigned.
REQ-012 Busy  output  1  high while the interval is being timed.

Function
REQ-013 The block SHALL implement states IDLE, RUN and DONE, all outputs registered.
REQ-014 The block SHALL detect rising edges of Exp_increase, Exp_decrease and Start, each against a one-cycle-delayed copy of that input.
REQ-015 In IDLE, an Exp_increase edge SHALL increment Exp_time by 1, saturating at T_MAX.
REQ-016 In IDLE, an Exp_decrease edge SHALL decrement Exp_time by 1, saturating at T_MIN.
REQ-017 Simultaneous Exp_increase and Exp_decrease edges in the same cycle SHALL leave Exp_time unchanged.
REQ-018 Button edges SHALL be ignored in RUN and DONE: Exp_time is frozen during an exposure, and the ignored edges are not queued.
REQ-019 IDLE->RUN on a Start rising edge; in the same cycle the ms counter loads Exp_time and the prescaler loads 0.
REQ-020 A button edge coinciding with the Start edge SHALL be ignored; the interval uses the pre-edge Exp_time.
REQ-021 In RUN, the prescaler counts 0..TICKS_PER_MS-1 and wraps; on each wrap the ms counter decrements by 1.
REQ-022 Exposure length and Ovf5 timing:
- N = Exp_time*TICKS_PER_MS.
- If the Start edge is sampled at clock edge k, Ovf5 SHALL be high from edge k+N to edge k+N+1: exactly one cycle.
- At edge k+N the state SHALL become DONE.
REQ-023 Busy SHALL be high exactly while the state is RUN.
REQ-024 DONE->IDLE when Start is sampled low; Start held high in DONE SHALL produce no further Ovf5.
REQ-025 Start sampled low in RUN SHALL abort: state returns to IDLE next cycle, counters clear, and Ovf5 is never asserted.
REQ-026 Counter widths:
- ms counter 5 bits.
- Prescaler ceil(log2(TICKS_PER_MS)) bits, minimum 1.
- No counter SHALL wrap below 0.

Reset
REQ-027 On Reset sampled high, the block SHALL set:
- state IDLE
- Exp_time = T_RESET
- Ovf5 = 0, Busy = 0
- ms counter and prescaler = 0
REQ-028 Reset SHALL take priority over all other inputs, including mid-RUN, where it aborts the interval without an Ovf5 pulse.
REQ-029 Edge-detect delay registers SHALL reset to 1, so inputs held high through reset release generate no edge.

Verification (TICKS_PER_MS=4, defaults otherwise)
REQ-030 Reset, then idle 3 cycles -> Exp_time=10, Ovf5=0, Busy=0.
REQ-031 25 Exp_increase pulses, then 40 Exp_decrease pulses -> Exp_time reads 30 then 2, with no wrap.
REQ-032 Exp_time=2, Start rises at edge k and is held -> Busy high edges k..k+8, Ovf5 high only edge k+8 to k+9, no second pulse while Start stays high.
REQ-033 Start rises, Exp_increase pulses at cycle 3 of RUN, Start drops at cycle 5 -> Exp_time unchanged, IDLE at next edge, Ovf5 never high.
REQ-034 Exp_increase and Exp_decrease rise in the same cycle -> Exp_time unchanged; Start held high across Reset release -> stays IDLE.
REQ-035 Reset asserted at cycle 20 of a 40-cycle RUN -> IDLE, Exp_time=10, Ovf5=0 thereafter.
